// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the fetch controller and its instruction buffer.
package fetch_controller_pkg;

    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is instruction-aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO with single-cycle flush; head entry is always visible.
module fetch_buffer
    import fetch_controller_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: storage is only two entries, so it is reset to give out_pc/out_instr a defined zero.
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: request FSM, PC sequencing and redirect handling.
// Defining FETCH_CTRL_PERF_EN adds a retired-fetch counter on fetch_count.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic [31:0]     fetch_count
);

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic [XLEN-1:0] req_pc, req_pc_next;
    logic [XLEN-1:0] redirect_target;
    logic            push, pop, flush;
    logic [1:0]      count, count_after;
    logic            resume;
    fetch_entry_t    head;

    assign redirect_target = align_pc(redirect_pc);
    assign flush           = redirect_valid;
    // A response arriving with a redirect belongs to the old path and is dropped.
    assign push            = (state == WAIT) && mem_rsp_valid && !redirect_valid;
    assign out_valid       = (count != 2'd0) && !redirect_valid;
    assign pop             = out_valid && out_ready;
    assign count_after     = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    assign resume          = fetch_en && (count_after < DEPTH);

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = (state == REQ) ? fetch_pc : '0;
    assign out_pc        = head.pc;
    assign out_instr     = head.instr;

    fetch_buffer u_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data ({req_pc, mem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= align_pc(RESET_PC);
            req_pc   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next    = state;
        fetch_pc_next = redirect_valid ? redirect_target : fetch_pc;
        req_pc_next   = req_pc;
        unique case (state)
            IDLE: begin
                if (fetch_en && (count < DEPTH)) state_next = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    // A request accepted in the redirect cycle still owes a response.
                    if (mem_req_ready)  state_next = DRAIN;
                    else if (!fetch_en) state_next = IDLE;
                end else if (mem_req_ready) begin
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + XLEN'(INSTR_BYTES);
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid)       state_next = resume ? REQ : IDLE;
                else if (redirect_valid) state_next = DRAIN;
            end
            DRAIN: begin
                if (mem_rsp_valid) state_next = resume ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    fetch_count <= '0;
        else if (pop) fetch_count <= fetch_count + 32'd1;
    end
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a memory model answers requests, a monitor checks decode output.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] fetch_count;

    int           errors = 0;
    int           checks = 0;
    fetch_entry_t exp_q[$];
    logic [63:0]  req_q[$];
    int unsigned  hs_count = 0;
    int           mem_lat = 1;
    bit           auto_sb = 1'b0;
    bit           pending = 1'b0;
    int           wait_cnt = 0;
    logic [63:0]  pend_addr = '0;

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013 ^ {a[47:32], 16'h0000};
    endfunction

    function automatic fetch_entry_t mk_entry(input logic [63:0] a);
        fetch_entry_t e;
        e.pc    = a;
        e.instr = instr_of(a);
        return e;
    endfunction

    function automatic logic [63:0] req_at(input int i);
        if (i < req_q.size()) return req_q[i];
        return 'x;
    endfunction

    function automatic logic [31:0] exp_fetch_count();
`ifdef FETCH_CTRL_PERF_EN
        return hs_count;
`else
        return 32'd0;
`endif
    endfunction

    // Memory model: decides handshakes on the falling edge, answers after mem_lat cycles.
    always @(negedge clk) begin
        if (reset) begin
            pending       = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end else begin
            mem_rsp_valid = 1'b0;
            if (pending) begin
                if (wait_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = instr_of(pend_addr);
                    pending       = 1'b0;
                    if (auto_sb) exp_q.push_back(mk_entry(pend_addr));
                end else begin
                    wait_cnt--;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                pending   = 1'b1;
                pend_addr = mem_req_addr;
                wait_cnt  = mem_lat - 1;
                req_q.push_back(mem_req_addr);
            end
        end
    end

    // Output monitor: every decode handshake pops and compares the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                if ({out_pc, out_instr} !== e) begin
                    errors++;
                    $display("FAIL out_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
            hs_count++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        out_ready      = 1'b0;
        mem_lat        = 1;
        auto_sb        = 1'b0;
        exp_q.delete();
        req_q.delete();
        hs_count       = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_req(input int n, input int max_cycles);
        int cyc = 0;
        while (req_q.size() < n && cyc < max_cycles) begin
            cycle();
            cyc++;
        end
        checks++;
        if (req_q.size() < n) begin
            errors++;
            $display("FAIL wait_req: got %0d requests, required %0d", req_q.size(), n);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < max_cycles) begin
            cycle();
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_drain: got %0d outputs pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, required 0", mem_req_valid); end
        if (mem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_req_addr: got %h, required 0", mem_req_addr); end
        if (out_valid !== 1'b0)     begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (out_pc !== 64'h0)       begin errors++; $display("FAIL rst_out_pc: got %h, required 0", out_pc); end
        if (out_instr !== 32'h0)    begin errors++; $display("FAIL rst_out_instr: got %h, required 0", out_instr); end
        if (fetch_count !== 32'h0)  begin errors++; $display("FAIL rst_fetch_count: got %0d, required 0", fetch_count); end
    endtask

    task automatic test_sequential();
        do_reset();
        exp_q.push_back(mk_entry(64'h0));
        exp_q.push_back(mk_entry(64'h4));
        exp_q.push_back(mk_entry(64'h8));
        out_ready = 1'b1;
        fetch_en  = 1'b1;
        wait_req(3, 40);
        fetch_en = 1'b0;
        wait_drain(40);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_at(i) !== 64'(i * 4)) begin
                errors++;
                $display("FAIL seq_addr%0d: got %h, required %h", i, req_at(i), 64'(i * 4));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en = 1'b1;
        repeat (12) cycle();
        checks += 3;
        if (req_q.size() != 2)      begin errors++; $display("FAIL bp_req_count: got %0d, required 2", req_q.size()); end
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b, required 0", mem_req_valid); end
        if (out_valid !== 1'b1)     begin errors++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
        exp_q.push_back(mk_entry(64'h0));
        exp_q.push_back(mk_entry(64'h4));
        exp_q.push_back(mk_entry(64'h8));
        out_ready = 1'b1;
        wait_req(3, 40);
        fetch_en = 1'b0;
        checks++;
        if (req_at(2) !== 64'h8) begin errors++; $display("FAIL bp_resume_addr: got %h, required 8", req_at(2)); end
        wait_drain(40);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        exp_q.push_back(mk_entry(64'h0));
        exp_q.push_back(mk_entry(64'h100));
        out_ready = 1'b1;
        fetch_en  = 1'b1;
        wait_req(2, 40);
        checks++;
        if (req_at(1) !== 64'h4) begin errors++; $display("FAIL rw_addr4: got %h, required 4", req_at(1)); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        cycle();
        redirect_valid = 1'b0;
        wait_req(3, 40);
        fetch_en = 1'b0;
        checks++;
        if (req_at(2) !== 64'h100) begin errors++; $display("FAIL rw_target: got %h, required 100", req_at(2)); end
        wait_drain(40);
    endtask

    task automatic test_redirect_drain();
        do_reset();
        mem_lat = 3;
        exp_q.push_back(mk_entry(64'h80));
        out_ready = 1'b1;
        fetch_en  = 1'b1;
        wait_req(1, 40);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        cycle();
        redirect_pc = 64'h83;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_drain_req: got %b, required 0", mem_req_valid); end
        wait_req(2, 40);
        fetch_en = 1'b0;
        checks++;
        if (req_at(1) !== 64'h80) begin errors++; $display("FAIL rd_target: got %h, required 80", req_at(1)); end
        wait_drain(60);
    endtask

    task automatic test_redirect_full();
        do_reset();
        fetch_en = 1'b1;
        repeat (12) cycle();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_full: got out_valid=%b, required 1", out_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h203;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid_masked: got %b, required 0", out_valid); end
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_flushed: got %b, required 0", out_valid); end
        exp_q.push_back(mk_entry(64'h200));
        out_ready = 1'b1;
        wait_req(3, 40);
        fetch_en = 1'b0;
        checks++;
        if (req_at(2) !== 64'h200) begin errors++; $display("FAIL rf_target: got %h, required 200", req_at(2)); end
        wait_drain(40);
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        exp_q.push_back(mk_entry(64'hFFFF_FFFF_FFFF_FFFC));
        exp_q.push_back(mk_entry(64'h0));
        out_ready = 1'b1;
        fetch_en  = 1'b1;
        wait_req(2, 40);
        fetch_en = 1'b0;
        checks += 2;
        if (req_at(0) !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h, required fffffffffffffffc", req_at(0)); end
        if (req_at(1) !== 64'h0) begin errors++; $display("FAIL wrap_zero: got %h, required 0", req_at(1)); end
        wait_drain(40);
    endtask

    task automatic test_perf_count();
        logic [31:0] want;
        do_reset();
        auto_sb   = 1'b1;
        out_ready = 1'b1;
        fetch_en  = 1'b1;
        wait_req(5, 60);
        fetch_en = 1'b0;
        repeat (4) cycle();
        wait_drain(40);
`ifdef FETCH_CTRL_PERF_EN
        want = 32'd5;
`else
        want = 32'd0;
`endif
        checks++;
        if (fetch_count !== want) begin errors++; $display("FAIL perf_count: got %0d, required %0d", fetch_count, want); end
    endtask

    task automatic test_back_to_back();
        logic        prev_valid = 1'b0;
        logic        prev_ready = 1'b0;
        logic [63:0] prev_addr = '0;
        do_reset();
        auto_sb  = 1'b1;
        mem_lat  = 2;
        fetch_en = 1'b1;
        repeat (80) begin
            if (prev_valid && !prev_ready) begin
                checks++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL b2b_hold: got valid=%b addr=%h, required valid=1 addr=%h",
                             mem_req_valid, mem_req_addr, prev_addr);
                end
            end
            prev_valid    = mem_req_valid;
            prev_addr     = mem_req_addr;
            mem_req_ready = 1'($urandom_range(0, 1));
            prev_ready    = mem_req_ready;
            out_ready     = 1'($urandom_range(0, 1));
            cycle();
        end
        mem_req_ready = 1'b1;
        fetch_en      = 1'b0;
        out_ready     = 1'b1;
        repeat (8) cycle();
        wait_drain(40);
        checks += 2;
        if (hs_count < 5) begin errors++; $display("FAIL b2b_traffic: got %0d outputs, required at least 5", hs_count); end
        if (fetch_count !== exp_fetch_count()) begin
            errors++;
            $display("FAIL b2b_fetch_count: got %0d, required %0d", fetch_count, exp_fetch_count());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_drain();
        test_redirect_full();
        test_wrap();
        test_perf_count();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries (legal values: 2 only).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_en  input  1  permits new memory requests when high.
REQ-006 redirect_valid  input  1  branch/jump redirect strobe, one cycle.
REQ-007 redirect_pc  input  64  redirect target address.
REQ-008 mem_req_valid  output  1  instruction-memory request valid.
REQ-009 mem_req_addr  output  64  request byte address, word-aligned.
REQ-010 mem_req_ready  input  1  memory accepts request.
REQ-011 mem_rsp_valid  input  1  response valid, arbitrary latency >= 1 cycle.
REQ-012 mem_rsp_data  input  32  fetched instruction.
REQ-013 out_valid  output  1  instruction available to decode.
REQ-014 out_ready  input  1  decode accepts instruction.
REQ-015 out_pc  output  64  PC of out_instr.
REQ-016 out_instr  output  32  instruction to decode.
REQ-017 fetch_count  output  32  retired-fetch counter (only with FETCH_CTRL_PERF_EN).

Function
REQ-018 FSM states IDLE, REQ, WAIT, DRAIN; reset state IDLE.
REQ-019 IDLE->REQ when fetch_en=1 and free slots (BUF_DEPTH - occupancy) >= 1.
REQ-020 REQ: mem_req_valid=1, mem_req_addr=fetch_pc; on mem_req_ready -> WAIT, fetch_pc += 4 (mod 2^64).
REQ-021 At most one outstanding request; no request while in WAIT or DRAIN.
REQ-022 WAIT: on mem_rsp_valid, push {request PC, mem_rsp_data} into buffer; -> REQ if fetch_en and a slot is free after this cycle's pop, else IDLE.
REQ-023 Buffer is FIFO; out_valid = buffer non-empty and redirect_valid=0; pop on out_valid & out_ready.
REQ-024 Simultaneous push and pop with buffer full is legal; occupancy unchanged.
REQ-025 Redirect: buffer flushed same cycle; fetch_pc <= {redirect_pc[63:2], 2'b00}; low two bits ignored.
REQ-026 Redirect in REQ without handshake: request withdrawn; next cycle REQ with new address (if fetch_en).
REQ-027 Redirect in REQ with mem_req_ready=1, or in WAIT without mem_rsp_valid: -> DRAIN.
REQ-028 Redirect coincident with mem_rsp_valid in WAIT: response discarded; -> REQ/IDLE per REQ-022 rules.
REQ-029 DRAIN: next mem_rsp_valid discarded, then -> REQ/IDLE; a further redirect in DRAIN updates fetch_pc only.
REQ-030 fetch_en low: no new requests; outstanding request completes normally.
REQ-031 mem_req_valid held with stable address until mem_req_ready or redirect.

Reset
REQ-032 Reset: state IDLE, fetch_pc=RESET_PC, buffer empty, mem_req_valid=0, out_valid=0, fetch_count=0.
REQ-033 Reset mid-WAIT/DRAIN: outstanding response after reset deassertion is ignored (the memory is reset on the same net).
REQ-034 out_pc, out_instr, mem_req_addr reset to 0 (mem_req_addr shows fetch_pc once in REQ).

Configuration
REQ-035 Macro FETCH_CTRL_PERF_EN defined: fetch_count increments on each out handshake, wraps at 2^32.
REQ-036 Macro undefined: fetch_count port present, tied to 0, no counter flops.

Structure
REQ-037 Shared package holds FSM state encoding typedef, XLEN=64, ILEN=32, INSTR_BYTES=4.
REQ-038 Sub-module fetch_buffer (2-entry FIFO with flush) is instantiated once; FSM and PC logic stay in top.

Verification
REQ-039 Reset, fetch_en=1, mem_req_ready=1, 1-cycle rsp: addresses 0,4,8 issued; out_pc 0,4,8 in order.
REQ-040 out_ready=0: exactly 2 instructions buffered, mem_req_valid stays 0; out_ready=1 resumes at address 8.
REQ-041 Redirect to 64'h100 while WAIT at address 4: rsp for 4 dropped, next request 64'h100, out_pc 64'h100.
REQ-042 Redirect to 64'h203 while buffer full: buffer empty next cycle, next request 64'h200.
REQ-043 fetch_pc 64'hFFFF_FFFF_FFFF_FFFC: following request address 64'h0.
REQ-044 With FETCH_CTRL_PERF_EN: 5 handshakes -> fetch_count=5; without it fetch_count=0.
